// File: rtl/wb_arb2_pkg.sv
// soc_bus_pkg: shared Wishbone bus definitions for the wb_arb2 arbiter.
//   - arbiter state encoding (IDLE / G0 / G1)
//   - default read data returned on a watchdog termination
//   - Wishbone address and data widths
package soc_bus_pkg;

  localparam int unsigned WbAddrW = 32;
  localparam int unsigned WbDataW = 32;

  localparam logic [WbDataW-1:0] ToRdtDefault = 32'hdead_dead;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StG0   = 2'b01,
    StG1   = 2'b10
  } arb_state_e;

endpackage

// File: rtl/wb_arb2_if.sv
// wb_arb2_if: bundle of every Wishbone signal around the two-master arbiter.
//   m0_* : CPU master side (cyc/stb/we/sel/adr/dat in, rdt/ack out)
//   m1_* : SPI-slave master side (same shape as m0)
//   s_*  : shared bus towards the address decoder (cyc/stb/we/sel/adr/dat out, rdt/ack in)
// Modports:
//   slave  : the arbiter's view (it is the slave of both masters)
//   master : the surrounding system's view (masters plus decoder)
interface wb_arb2_if;
  import soc_bus_pkg::*;

  logic               m0_cyc;
  logic               m0_stb;
  logic               m0_we;
  logic [3:0]         m0_sel;
  logic [WbAddrW-1:0] m0_adr;
  logic [WbDataW-1:0] m0_dat;
  logic [WbDataW-1:0] m0_rdt;
  logic               m0_ack;

  logic               m1_cyc;
  logic               m1_stb;
  logic               m1_we;
  logic [3:0]         m1_sel;
  logic [WbAddrW-1:0] m1_adr;
  logic [WbDataW-1:0] m1_dat;
  logic [WbDataW-1:0] m1_rdt;
  logic               m1_ack;

  logic               s_cyc;
  logic               s_stb;
  logic               s_we;
  logic [3:0]         s_sel;
  logic [WbAddrW-1:0] s_adr;
  logic [WbDataW-1:0] s_dat;
  logic [WbDataW-1:0] s_rdt;
  logic               s_ack;

  modport slave (
    input  m0_cyc, m0_stb, m0_we, m0_sel, m0_adr, m0_dat,
    output m0_rdt, m0_ack,
    input  m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat,
    output m1_rdt, m1_ack,
    output s_cyc, s_stb, s_we, s_sel, s_adr, s_dat,
    input  s_rdt, s_ack
  );

  modport master (
    output m0_cyc, m0_stb, m0_we, m0_sel, m0_adr, m0_dat,
    input  m0_rdt, m0_ack,
    output m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat,
    input  m1_rdt, m1_ack,
    input  s_cyc, s_stb, s_we, s_sel, s_adr, s_dat,
    output s_rdt, s_ack
  );

endinterface

// File: rtl/wb_wdt.sv
// wb_wdt: bus-cycle watchdog for wb_arb2.
// Counts consecutive stalled strobe cycles and flags a forced termination on the
// Cycles-th one; also holds the sticky timeout flag.
// Ports:
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   run_i    : strobe of the granted master is high
//   kick_i   : slave ack or arbiter state change; restarts the count
//   clr_i    : clears the sticky timeout flag
//   expire_o : this cycle is a forced termination
//   to_o     : sticky timeout flag, set the edge after expire_o
module wb_wdt #(
  parameter int unsigned Cycles = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic kick_i,
  input  logic clr_i,
  output logic expire_o,
  output logic to_o
);

  localparam int unsigned CntW = (Cycles > 2) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;

  assign expire_o = run_i & ~kick_i & (cnt_q == CntMax);
  assign to_o     = to_q;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    // Clearing at the terminal count means the counter can never wrap.
    if (!run_i || kick_i || expire_o) begin
      cnt_d = '0;
    end
    to_d = to_q;
    if (clr_i) begin
      to_d = 1'b0;
    end
    // A new timeout beats a simultaneous clear.
    if (expire_o) begin
      to_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone classic arbiter with round-robin fairness and an
// optional bus-cycle watchdog (build with WB_ARB2_WDT_EN defined to include it).
// Ports:
//   wb_clk  : clock, rising edge
//   wb_rst  : asynchronous active-high reset
//   bus     : wb_arb2_if.slave, both master ports plus the shared decoder port
//   wdt_to  : sticky watchdog-timeout flag (tied 0 without the watchdog)
//   wdt_clr : clears wdt_to (ignored without the watchdog)
// Parameters:
//   WDT_CYCLES : stalled-strobe cycles before a forced termination (2..65535)
//   TO_RDT     : read data returned to the master on a forced termination
module wb_arb2
  import soc_bus_pkg::*;
#(
  parameter int unsigned        WDT_CYCLES = 64,
  parameter logic [WbDataW-1:0] TO_RDT     = ToRdtDefault
) (
  input  logic     wb_clk,
  input  logic     wb_rst,
  wb_arb2_if.slave bus,
  output logic     wdt_to,
  input  logic     wdt_clr
);

  if (WDT_CYCLES < 2 || WDT_CYCLES > 65535) begin : g_bad_wdt_cycles
    $error("wb_arb2: WDT_CYCLES must lie in 2..65535");
  end

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       gnt0, gnt1;
  logic       cyc_raw, stb_raw;
  logic       expire;

  assign gnt0 = (state_q == StG0);
  assign gnt1 = (state_q == StG1);

  // Grant FSM. IDLE always sits between two grants, which costs one dead cycle
  // but keeps the hand-over trivially glitch-free.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (bus.m0_cyc && bus.m1_cyc) begin
          state_d = last_q ? StG0 : StG1;
        end else if (bus.m0_cyc) begin
          state_d = StG0;
        end else if (bus.m1_cyc) begin
          state_d = StG1;
        end
      end
      StG0: begin
        if (!bus.m0_cyc) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end
      end
      StG1: begin
        if (!bus.m1_cyc) begin
          state_d = StIdle;
          last_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign cyc_raw = (bus.m0_cyc & gnt0) | (bus.m1_cyc & gnt1);
  assign stb_raw = (bus.m0_stb & gnt0) | (bus.m1_stb & gnt1);

`ifdef WB_ARB2_WDT_EN
  logic kick;

  assign kick = bus.s_ack | (state_d != state_q);

  // run uses the unforced strobe so the forced drop cannot feed back into expire.
  wb_wdt #(
    .Cycles(WDT_CYCLES)
  ) u_wdt (
    .clk_i   (wb_clk),
    .rst_i   (wb_rst),
    .run_i   (stb_raw),
    .kick_i  (kick),
    .clr_i   (wdt_clr),
    .expire_o(expire),
    .to_o    (wdt_to)
  );
`else
  logic unused_wdt_clr;

  assign unused_wdt_clr = wdt_clr;
  assign expire         = 1'b0;
  assign wdt_to         = 1'b0;
`endif

  // Shared bus: m1 only while G1, otherwise m0 (including IDLE and reset).
  assign bus.s_cyc = cyc_raw & ~expire;
  assign bus.s_stb = stb_raw & ~expire;
  assign bus.s_we  = gnt1 ? bus.m1_we  : bus.m0_we;
  assign bus.s_sel = gnt1 ? bus.m1_sel : bus.m0_sel;
  assign bus.s_adr = gnt1 ? bus.m1_adr : bus.m0_adr;
  assign bus.s_dat = gnt1 ? bus.m1_dat : bus.m0_dat;

  // Acks are gated by the live strobe so a late ack after a termination is dropped.
  assign bus.m0_ack = gnt0 & ((bus.s_ack & stb_raw & ~expire) | expire);
  assign bus.m1_ack = gnt1 & ((bus.s_ack & stb_raw & ~expire) | expire);

  assign bus.m0_rdt = (gnt0 & expire) ? TO_RDT : bus.s_rdt;
  assign bus.m1_rdt = (gnt1 & expire) ? TO_RDT : bus.s_rdt;

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: self-checking bench for wb_arb2.
// A small decoder model acks one cycle after it sees s_stb (or never, when stalling)
// and returns ~s_adr as read data. Expected acks are queued as masters raise cyc and
// popped when the DUT acks.
module tb_wb_arb2;
  import soc_bus_pkg::*;

  localparam int unsigned Wdt = 8;
  localparam logic [31:0] A0  = 32'h0000_0200;
  localparam logic [31:0] A1  = 32'h0000_0300;

  typedef struct {
    int          m;
    logic [31:0] rdt;
  } exp_t;

  logic wb_clk = 1'b0;
  logic wb_rst;
  logic wdt_to;
  logic wdt_clr;
  logic dec_ack;
  logic dec_never;
  logic dec_fixed;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   gseq[$];
  int   gaps[$];

  wb_arb2_if bus ();

  always #5 wb_clk = ~wb_clk;

  wb_arb2 #(
    .WDT_CYCLES(Wdt),
    .TO_RDT    (32'hdead_dead)
  ) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus),
    .wdt_to (wdt_to),
    .wdt_clr(wdt_clr)
  );

  always @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) dec_ack <= 1'b0;
    else        dec_ack <= bus.s_stb & ~dec_ack & ~dec_never;
  end
  assign bus.s_ack = dec_ack;
  assign bus.s_rdt = dec_fixed ? 32'h1234_5678 : ~bus.s_adr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic drv(input int m, input logic on, input logic we, input logic [31:0] adr);
    if (m == 0) begin
      bus.m0_cyc = on; bus.m0_stb = on; bus.m0_we = we;
      bus.m0_adr = adr; bus.m0_dat = adr ^ 32'hffff_0000; bus.m0_sel = 4'hf;
    end else begin
      bus.m1_cyc = on; bus.m1_stb = on; bus.m1_we = we;
      bus.m1_adr = adr; bus.m1_dat = adr ^ 32'h0f0f_0000; bus.m1_sel = 4'h3;
    end
  endtask

  task automatic do_reset();
    step();
    wb_rst = 1'b1;
    step();
    step();
    wb_rst = 1'b0;
  endtask

  // Both masters request from IDLE; each drops cyc for one cycle after its ack and
  // re-requests. Grants must alternate starting with m0, two s_cyc-low cycles apart
  // (the grantee's cyc-low cycle plus the IDLE cycle).
  task automatic contend(input int n);
    int   got  = 0;
    int   gap  = 0;
    int   prev = 2;
    int   cur;
    bit   drop0 = 0, drop1 = 0, rise0 = 0, rise1 = 0;
    exp_t e;
    gseq.delete();
    gaps.delete();
    exp_q.delete();
    step();
    drv(0, 1'b1, 1'b0, A0);
    drv(1, 1'b1, 1'b0, A1);
    exp_q.push_back('{0, ~A0});
    exp_q.push_back('{1, ~A1});
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge wb_clk);
      cur = !bus.s_cyc ? 2 : ((bus.s_adr == A1) ? 1 : 0);
      if (cur != 2 && prev == 2) begin
        if (gseq.size() > 0) gaps.push_back(gap);
        gseq.push_back(cur);
        gap = 0;
      end else if (cur == 2) begin
        gap++;
      end
      prev = cur;
      if (bus.m0_ack || bus.m1_ack) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ack", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("ack_exclusive", bus.m0_ack & bus.m1_ack, 0);
          chk("ack_master", bus.m1_ack, e.m);
          chk("ack_rdt", bus.m1_ack ? bus.m1_rdt : bus.m0_rdt, e.rdt);
        end
        got++;
        if (bus.m1_ack) drop1 = 1;
        else            drop0 = 1;
      end
      step();
      if (rise0) begin drv(0, 1'b1, 1'b0, A0); exp_q.push_back('{0, ~A0}); rise0 = 0; end
      if (rise1) begin drv(1, 1'b1, 1'b0, A1); exp_q.push_back('{1, ~A1}); rise1 = 0; end
      if (drop0) begin drv(0, 1'b0, 1'b0, A0); drop0 = 0; rise0 = 1; end
      if (drop1) begin drv(1, 1'b0, 1'b0, A1); drop1 = 0; rise1 = 1; end
    end
    chk("grants_done", got, n);
    chk("grant_count", gseq.size(), n);
    foreach (gseq[i]) chk("grant_order", gseq[i], i % 2);
    chk("gap_count", gaps.size(), n - 1);
    foreach (gaps[i]) chk("idle_gap", gaps[i], 2);
    drv(0, 1'b0, 1'b0, A0);
    drv(1, 1'b0, 1'b0, A1);
    repeat (3) step();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed still running, expected finished");
    $fatal(1, "tb_wb_arb2 timeout");
  end

  initial begin
    exp_t e;
    int   stb_n;
    int   n_ack;
    bit   acked;
    wb_rst    = 1'b1;
    wdt_clr   = 1'b0;
    dec_never = 1'b0;
    dec_fixed = 1'b0;
    drv(0, 1'b0, 1'b1, 32'h55);
    drv(1, 1'b0, 1'b0, 32'haa);

    // Reset values
    #12;
    chk("rst_s_cyc", bus.s_cyc, 0);
    chk("rst_s_stb", bus.s_stb, 0);
    chk("rst_m0_ack", bus.m0_ack, 0);
    chk("rst_m1_ack", bus.m1_ack, 0);
    chk("rst_wdt_to", wdt_to, 0);
    chk("rst_s_adr_m0", bus.s_adr, 32'h55);
    chk("rst_s_we_m0", bus.s_we, 1);
    step();
    wb_rst = 1'b0;

    // m0 single read, no contention
    dec_fixed = 1'b1;
    step();
    drv(0, 1'b1, 1'b0, 32'h100);
    exp_q.push_back('{0, 32'h1234_5678});
    @(negedge wb_clk);
    chk("rd_cyc_idle", bus.s_cyc, 0);
    @(negedge wb_clk);
    chk("rd_cyc_grant", bus.s_cyc, 1);
    chk("rd_stb_grant", bus.s_stb, 1);
    chk("rd_adr", bus.s_adr, 32'h100);
    chk("rd_ack_early", bus.m0_ack, 0);
    @(negedge wb_clk);
    chk("rd_m0_ack", bus.m0_ack, 1);
    chk("rd_m1_ack", bus.m1_ack, 0);
    e = exp_q.pop_front();
    chk("rd_m0_rdt", bus.m0_rdt, e.rdt);
    step();
    drv(0, 1'b0, 1'b0, 32'h100);
    dec_fixed = 1'b0;
    repeat (2) step();

    // Tie after reset, then continuous round-robin
    do_reset();
    contend(6);

`ifdef WB_ARB2_WDT_EN
    // Watchdog expiry on an m1 write the decoder never acks
    dec_never = 1'b1;
    step();
    drv(1, 1'b1, 1'b1, A1);
    exp_q.push_back('{1, 32'hdead_dead});
    stb_n = 0;
    acked = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge wb_clk);
      if (bus.m1_ack) begin
        e = exp_q.pop_front();
        chk("wdt_ack_cycle", stb_n + 1, Wdt);
        chk("wdt_stb_forced", bus.s_stb, 0);
        chk("wdt_cyc_forced", bus.s_cyc, 0);
        chk("wdt_rdt", bus.m1_rdt, e.rdt);
        chk("wdt_m0_ack", bus.m0_ack, 0);
        chk("wdt_to_not_yet", wdt_to, 0);
        acked = 1;
        break;
      end
      if (bus.s_stb) stb_n++;
    end
    chk("wdt_acked", acked, 1);
    step();
    drv(1, 1'b0, 1'b0, A1);
    @(negedge wb_clk);
    chk("wdt_to_set", wdt_to, 1);
    step();
    wdt_clr = 1'b1;
    @(negedge wb_clk);
    chk("wdt_to_held", wdt_to, 1);
    step();
    wdt_clr = 1'b0;
    @(negedge wb_clk);
    chk("wdt_to_cleared", wdt_to, 0);
    dec_never = 1'b0;
    repeat (2) step();

    // Start a G1 transfer that the reset below interrupts
    dec_never = 1'b1;
    step();
    drv(1, 1'b1, 1'b1, A1);
    repeat (3) @(negedge wb_clk);
    chk("g1_active", bus.s_cyc, 1);
`else
    // Watchdog compiled out: a stalled slave holds the grant
    dec_never = 1'b1;
    step();
    drv(1, 1'b1, 1'b1, A1);
    n_ack = 0;
    repeat (1000) begin
      @(negedge wb_clk);
      if (bus.m0_ack || bus.m1_ack) n_ack++;
    end
    chk("stall_no_ack", n_ack, 0);
    chk("stall_wdt_to", wdt_to, 0);
    chk("stall_cyc", bus.s_cyc, 1);
    chk("stall_adr_m1", bus.s_adr, A1);
    chk("stall_we_m1", bus.s_we, 1);
`endif

    // Asynchronous reset mid-transfer
    wb_rst = 1'b1;
    #1;
    chk("rst_async_cyc", bus.s_cyc, 0);
    chk("rst_async_ack", bus.m1_ack, 0);
    drv(1, 1'b0, 1'b0, A1);
    step();
    step();
    wb_rst    = 1'b0;
    dec_never = 1'b0;

    // After release the first tie must go to m0 again
    contend(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
